// File: rtl/gray_counter_param.sv
// gray_counter_param: up/down binary counter with a registered Gray mirror.
// Define GRAY_COUNTER_PARAM_CHECK_EN to add the sticky Gray_Err_Out step checker.
module gray_counter_param #(
    parameter int               WIDTH       = 4,
    parameter bit               SATURATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Enable_In,
    input  logic             Up_Downb_In,
    input  logic             Load_In,
    input  logic [WIDTH-1:0] Load_Gray_In,
    output logic [WIDTH-1:0] Gray_Count_Out,
    output logic [WIDTH-1:0] Binary_Count_Out,
    output logic             Terminal_Count_Out,
    output logic             Wrap_Out
`ifdef GRAY_COUNTER_PARAM_CHECK_EN
    ,
    output logic             Gray_Err_Out
`endif
);

    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VALUE ^ (RESET_VALUE >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_at_end;
    logic             w_wrap_next;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_load_bin[i] = ^(Load_Gray_In >> i);
        end
    end

    assign w_at_end = Up_Downb_In ? (r_bin == ALL_ONES) : (r_bin == '0);
    assign w_step   = Up_Downb_In ? (r_bin + ONE) : (r_bin - ONE);

    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (Load_In) begin
            w_bin_next = w_load_bin;
        end else if (Enable_In) begin
            if (!(w_at_end && SATURATE)) begin
                w_bin_next = w_step;
            end
            w_wrap_next = w_at_end && !SATURATE;
        end
    end

    // The load path takes the Gray input verbatim rather than re-encoding.
    assign w_gray_next = Load_In ? Load_Gray_In
                                 : (w_bin_next ^ (w_bin_next >> 1));

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_bin  <= RESET_VALUE;
            r_gray <= RESET_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign Gray_Count_Out     = r_gray;
    assign Binary_Count_Out   = r_bin;
    assign Wrap_Out           = r_wrap;
    assign Terminal_Count_Out = w_at_end;

`ifdef GRAY_COUNTER_PARAM_CHECK_EN
    logic [WIDTH-1:0] r_gray_prev;
    logic             r_chk_vld;
    logic             r_gray_err;
    logic [WIDTH-1:0] w_gray_diff;
    logic             w_step_bad;

    // More than one bit set in the diff means a multi-bit Gray step.
    assign w_gray_diff = r_gray ^ r_gray_prev;
    assign w_step_bad  = r_chk_vld &&
                         ((w_gray_diff & (w_gray_diff - ONE)) != '0);

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_gray_prev <= RESET_GRAY;
            r_chk_vld   <= 1'b0;
            r_gray_err  <= 1'b0;
        end else begin
            r_gray_prev <= r_gray;
            r_chk_vld   <= !Load_In;
            r_gray_err  <= r_gray_err | w_step_bad;
        end
    end

    assign Gray_Err_Out = r_gray_err;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three configurations driven in lockstep
// and compared each cycle against an arithmetic reference model.
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       up  = 1'b1;
    logic       ld  = 1'b0;
    logic [7:0] lg  = '0;

    logic [3:0] g0, b0, g1, b1;
    logic [7:0] g2, b2;
    logic       t0, w0, t1, w1, t2, w2;
`ifdef GRAY_COUNTER_PARAM_CHECK_EN
    logic       e0, e1, e2;
    logic [7:0] fv;
`endif

    int errors = 0;
    int checks = 0;

    localparam int          MW [3] = '{4, 4, 8};
    localparam int unsigned MRV[3] = '{0, 5, 0};
    localparam bit          MS [3] = '{1'b0, 1'b1, 1'b0};

    int unsigned mb[3];
    bit          mw[3];

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(4'd0)) dut0 (
        .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Up_Downb_In(up),
        .Load_In(ld), .Load_Gray_In(lg[3:0]), .Gray_Count_Out(g0),
        .Binary_Count_Out(b0), .Terminal_Count_Out(t0), .Wrap_Out(w0)
`ifdef GRAY_COUNTER_PARAM_CHECK_EN
        , .Gray_Err_Out(e0)
`endif
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(4'd5)) dut1 (
        .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Up_Downb_In(up),
        .Load_In(ld), .Load_Gray_In(lg[3:0]), .Gray_Count_Out(g1),
        .Binary_Count_Out(b1), .Terminal_Count_Out(t1), .Wrap_Out(w1)
`ifdef GRAY_COUNTER_PARAM_CHECK_EN
        , .Gray_Err_Out(e1)
`endif
    );

    gray_counter_param #(.WIDTH(8), .SATURATE(1'b0), .RESET_VALUE(8'd0)) dut2 (
        .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Up_Downb_In(up),
        .Load_In(ld), .Load_Gray_In(lg), .Gray_Count_Out(g2),
        .Binary_Count_Out(b2), .Terminal_Count_Out(t2), .Wrap_Out(w2)
`ifdef GRAY_COUNTER_PARAM_CHECK_EN
        , .Gray_Err_Out(e2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Gray decode by exhaustive search over the code space.
    function automatic int unsigned g2b(input int unsigned g,
                                        input int unsigned mx);
        for (int unsigned b = 0; b <= mx; b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return 0;
    endfunction

    function automatic void mstep(input int k);
        int unsigned mx;
        mx = (32'd1 << MW[k]) - 1;
        if (rst) begin
            mb[k] = MRV[k];
            mw[k] = 1'b0;
        end else if (ld) begin
            mb[k] = g2b(lg & mx, mx);
            mw[k] = 1'b0;
        end else if (en) begin
            if (up ? (mb[k] == mx) : (mb[k] == 0)) begin
                if (MS[k]) begin
                    mw[k] = 1'b0;
                end else begin
                    mb[k] = up ? 0 : mx;
                    mw[k] = 1'b1;
                end
            end else begin
                mb[k] = up ? mb[k] + 1 : mb[k] - 1;
                mw[k] = 1'b0;
            end
        end else begin
            mw[k] = 1'b0;
        end
    endfunction

    task automatic check_all();
        logic [31:0] ob[3], og[3];
        logic        ot[3], ow[3];
        int unsigned mx;
        ob[0] = 32'(b0); ob[1] = 32'(b1); ob[2] = 32'(b2);
        og[0] = 32'(g0); og[1] = 32'(g1); og[2] = 32'(g2);
        ot[0] = t0; ot[1] = t1; ot[2] = t2;
        ow[0] = w0; ow[1] = w1; ow[2] = w2;
        for (int k = 0; k < 3; k++) begin
            mx = (32'd1 << MW[k]) - 1;
            chk($sformatf("bin%0d", k), ob[k], mb[k]);
            chk($sformatf("gray%0d", k), og[k], mb[k] ^ (mb[k] >> 1));
            chk($sformatf("wrap%0d", k), 32'(ow[k]), 32'(mw[k]));
            chk($sformatf("tc%0d", k), 32'(ot[k]),
                32'(up ? (mb[k] == mx) : (mb[k] == 0)));
        end
`ifdef GRAY_COUNTER_PARAM_CHECK_EN
        chk("err0", 32'(e0), 32'd0);
        chk("err1", 32'(e1), 32'd0);
        chk("err2", 32'(e2), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) mstep(k);
        #1;
        check_all();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mb[k] = 0;
            mw[k] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        tick();
        chk("rst_bin0", 32'(b0), 32'd0);
        chk("rst_gray1", 32'(g1), 32'd7);
        rst = 1'b0;

        // Full up cycle with wrap
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                chk("up15_gray", 32'(g0), 32'h8);
                chk("up15_tc", 32'(t0), 32'd1);
            end
            if (i == 16) begin
                chk("up16_gray", 32'(g0), 32'h0);
                chk("up16_wrap", 32'(w0), 32'd1);
            end
        end
        en = 1'b0;
        tick();
        chk("hold_wrap", 32'(w0), 32'd0);

        // Down wrap from zero
        rst = 1'b1; up = 1'b0;
        tick();
        chk("down_tc0", 32'(t0), 32'd1);
        rst = 1'b0; en = 1'b1;
        tick();
        chk("down_bin", 32'(b0), 32'd15);
        chk("down_gray", 32'(g0), 32'h8);
        chk("down_wrap", 32'(w0), 32'd1);
        en = 1'b0;
        tick();
        chk("down_wrap_end", 32'(w0), 32'd0);

        // Load wins over enable
        rst = 1'b1;
        tick();
        rst = 1'b0; ld = 1'b1; en = 1'b1; up = 1'b1; lg = 8'h0D;
        tick();
        chk("load_bin", 32'(b0), 32'd9);
        chk("load_gray", 32'(g0), 32'hD);
        ld = 1'b0;
        tick();
        chk("load_next_bin", 32'(b0), 32'd10);
        chk("load_next_gray", 32'(g0), 32'hF);

        // Saturation
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1; up = 1'b1;
        repeat (20) tick();
        chk("sat_bin", 32'(b1), 32'd15);
        chk("sat_gray", 32'(g1), 32'h8);
        up = 1'b0;
        tick();
        chk("sat_down_bin", 32'(b1), 32'd14);
        chk("sat_down_gray", 32'(g1), 32'h9);

        // Reset beats load and enable
        rst = 1'b1;
        tick();
        rst = 1'b0; up = 1'b1; en = 1'b1;
        repeat (6) tick();
        chk("rv_count", 32'(b1), 32'd11);
        rst = 1'b1; ld = 1'b1; lg = 8'hFF;
        tick();
        chk("rv_bin", 32'(b1), 32'd5);
        chk("rv_gray", 32'(g1), 32'h7);
        chk("rv_wrap", 32'(w1), 32'd0);
        rst = 1'b0; ld = 1'b0; en = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1) == 1;
            lg  = 8'($urandom);
            tick();
        end

`ifdef GRAY_COUNTER_PARAM_CHECK_EN
        // Inject a two-bit Gray step
        rst = 1'b0; ld = 1'b0; en = 1'b0;
        tick();
        tick();
        fv = 8'(mb[2] ^ (mb[2] >> 1)) ^ 8'h03;
        force dut2.r_gray = fv;
        @(posedge clk);
        #1;
        chk("force_err", 32'(e2), 32'd1);
        @(posedge clk);
        #1;
        chk("force_err_sticky", 32'(e2), 32'd1);
        release dut2.r_gray;
        rst = 1'b1;
        tick();
        chk("force_err_clr", 32'(e2), 32'd0);
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
